bl616_uart_tx: RTL and testbench
================================

// Module: bl616_uart_tx
// PURPOSE
//  FPGA->BL616 half of the MCU UART link: serialises status/response bytes onto uart_tx.
//  Sits beside iosys_bl616 (RX side) in the clk_48m domain.
//  Buffered by a small FIFO so core-side producers push bytes without waiting on the line.
//  Frame: 8N1 by default, LSB first, line idles high.
// PARAMETERS
//  CLK_DIV   24   clk cycles per bit (48 MHz / 2 Mbaud); legal range 4..65535
//  FIFO_AW   4    FIFO address width; depth = 2**FIFO_AW bytes
// PORTS
//  clk         in   1          system clock (clk_48m)
//  reset_n     in   1          asynchronous reset, active low
//  tx_data     in   8          byte to send
//  tx_valid    in   1          tx_data valid; byte accepted when tx_valid & tx_ready at posedge
//  tx_ready    out  1          FIFO can accept: ~fifo_full & ~flush (combinational)
//  flush       in   1          drop all queued bytes; the frame in flight completes
//  uart_tx     out  1          serial line to BL616, registered output
//  busy        out  1          frame in flight or FIFO non-empty
//  fifo_level  out  FIFO_AW+1  bytes queued, 0..2**FIFO_AW (excludes the frame in flight)
// BEHAVIOUR
//  - Reset, asynchronous: uart_tx=1, busy=0, fifo_level=0, FSM=IDLE, baud/bit counters=0.
//    tx_ready=1 once reset_n is high and flush=0.
//  - FIFO:
//    - Push on handshake; pop only by the FSM.
//    - Same-cycle push+pop: level unchanged. Pointers wrap modulo 2**FIFO_AW.
//    - Full: tx_ready=0; tx_valid is ignored, with no loss because the handshake is not met.
//    - Empty: no pop.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP.
//    - IDLE: if FIFO non-empty, pop into shift reg, go START. uart_tx=1.
//    - START: uart_tx=0 for CLK_DIV cycles, then DATA.
//    - DATA: shift out bits 0..7, CLK_DIV cycles each. A 3-bit counter exits to PARITY/STOP after bit 7.
//    - STOP: uart_tx=1 for CLK_DIV cycles.
//      - On its last cycle, if FIFO non-empty, pop and go START directly (no idle gap).
//      - Otherwise go IDLE.
//  - Baud counter: 0..CLK_DIV-1. It resets to 0 on every state entry, so every bit lasts exactly CLK_DIV cycles.
//  - Latency: with FIFO empty and FSM IDLE, handshake at edge N -> pop at edge N+1 -> uart_tx=0 from edge N+2.
//  - Frame length 10*CLK_DIV cycles (11*CLK_DIV with parity); back-to-back bytes have no gap.
//  - busy = (FSM != IDLE) | (fifo_level != 0).
//  - flush:
//    - Level-sensitive. While high, rd_ptr := wr_ptr each cycle, so level=0, and tx_ready=0.
//    - The current frame finishes unchanged; no further pops occur.
//    - flush together with tx_valid: the byte is not accepted.
//  - Reset mid-frame: line returns high immediately; queued bytes are lost. The partial frame is
//    aborted and BL616 sees a framing error, which is accepted.
// CONFIGURATION
//  UART_TX_PARITY_EN:
//   - Defined: PARITY state inserted after DATA. It drives even parity (^byte) for CLK_DIV cycles;
//     frame = 11 bits (8E1).
//   - Undefined: no PARITY state, 8N1. The BL616 firmware UART setting must match the build.
// TESTING
//  1. Reset, then one push 0xA5, CLK_DIV=24 -> uart_tx falls 2 cycles after the handshake.
//     Line reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 24 cycles. busy drops 240 cycles after the start edge.
//  2. Push 0x00,0xFF,0x55 back-to-back -> three contiguous frames, no idle cycles between stop and next start.
//     fifo_level peaks at 2.
//  3. Hold tx_valid with FIFO_AW=4 while the line is busy -> 16 accepted, tx_ready=0 at level 16.
//     Simultaneous pop+push keeps level at 16 with no byte lost. All 17 bytes are received in order.
//  4. Queue 5 bytes, assert flush 1 cycle mid-DATA of the first -> first frame completes intact,
//     level=0, tx_valid ignored during flush. No further start bits; busy=0 after the stop bit.
//  5. Assert reset_n=0 during DATA bit 3 -> uart_tx=1 and busy=0 asynchronously.
//     After release, a push 0x3C transmits a clean frame.
//  6. With UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 264 cycles.

Source files
------------

// File: rtl/bl616_uart_tx_if.sv
// Byte handshake between core-side producers and the BL616 UART transmitter.
// The master drives tx_data/tx_valid; the transmitter returns tx_ready.
interface bl616_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bl616_uart_tx.sv
// FPGA->BL616 UART transmitter: FIFO-buffered, 8N1 LSB first (8E1 with UART_TX_PARITY_EN).
// Latency: handshake at edge N -> pop at N+1 -> start bit on uart_tx from N+2; frames back-to-back.
// Backpressure: tx_ready = ~full & ~flush; flush drops the queue, the frame in flight completes.
module bl616_uart_tx #(
  parameter int CLK_DIV = 24,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  bl616_uart_tx_if.slave    tx,
  input  logic              flush,
  output logic              uart_tx,
  output logic              busy,
  output logic [FIFO_AW:0]  fifo_level
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [7:0]         rd_dat;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               pop_slot;

  logic [2:0]         state;
  logic [15:0]        baud_cnt;
  logic               baud_last;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               line;
`ifdef UART_TX_PARITY_EN
  logic               par;
`endif

  // Pointers carry one extra bit so a full queue still reads as DEPTH.
  assign fifo_level  = wr_ptr - rd_ptr;
  assign fifo_full   = fifo_level[FIFO_AW];
  assign fifo_empty  = (fifo_level == '0);
  assign rd_dat      = mem[rd_ptr[FIFO_AW-1:0]];

  assign tx.tx_ready = ~fifo_full & ~flush;
  assign push        = tx.tx_valid & tx.tx_ready;

  assign baud_last   = (baud_cnt == BAUD_LAST);
  assign pop_slot    = (state == ST_IDLE) | ((state == ST_STOP) & baud_last);
  assign pop         = pop_slot & ~fifo_empty & ~flush;

  assign busy        = (state != ST_IDLE) | ~fifo_empty;
  assign uart_tx     = line;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= tx.tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shreg <= rd_dat;
`ifdef UART_TX_PARITY_EN
            par   <= ^rd_dat;
`endif
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            // Chaining straight into START keeps queued bytes gap-free on the line.
            if (pop) begin
              shreg <= rd_dat;
`ifdef UART_TX_PARITY_EN
              par   <= ^rd_dat;
`endif
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          baud_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Line is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line <= 1'b1;
    end else begin
      case (state)
        ST_START: line <= 1'b0;
        ST_DATA:  line <= shreg[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: line <= par;
`endif
        default:  line <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bl616_uart_tx.sv
// Directed bench for bl616_uart_tx: cycle-exact single frame, back-to-back, full FIFO, flush, mid-frame reset.
// A background receiver decodes the line at mid-bit and records bytes, parity bits and start times.
module tb_bl616_uart_tx;

  localparam int CLK_DIV = 24;
  localparam int FIFO_AW = 4;
  localparam int PERIOD  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             uart_tx;
  logic             busy;
  logic [FIFO_AW:0] fifo_level;

  bl616_uart_tx_if tx_if ();

  bl616_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx         (tx_if),
    .flush      (flush),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  int total;
  int bad;

  logic [7:0] rx_q [$];
  logic       rx_p [$];
  longint     rx_t [$];
  int         rx_ferr;
  logic       mon_en;

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  initial begin
    #(PERIOD * 60000);
    $display("FAIL watchdog: simulation still running at cycle 60000, required finish earlier");
    $fatal(1);
  end

  // Receiver: first posedge seeing 0 marks the start bit; sample each bit at its middle.
  initial begin : monitor
    logic [10:0] fr;
    logic        ok;
    longint      t0;
    int          w;
    forever begin
      @(posedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        t0 = $time;
        ok = 1'b1;
        fr = '0;
        for (int b = 0; b < NB && ok; b++) begin
          w = (b == 0) ? CLK_DIV / 2 : CLK_DIV;
          for (int k = 0; k < w; k++) begin
            @(posedge clk);
            if (!mon_en) ok = 1'b0;
          end
          fr[b] = uart_tx;
        end
        if (ok) begin
          rx_q.push_back(fr[8:1]);
          rx_p.push_back(fr[9]);
          rx_t.push_back(t0);
          if (fr[0] !== 1'b0 || fr[NB-1] !== 1'b1) rx_ferr++;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx;
    rx_q.delete();
    rx_p.delete();
    rx_t.delete();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    flush = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    mon_en = 1'b0;
    rx_ferr = 0;
    repeat (3) step;
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", uart_tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    reset_n = 1'b1;
    step;
    total++;
    if (tx_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_if.tx_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    logic [NB-1:0] ef;
    logic          bit_ok;
    logic          busy_late;
`ifdef UART_TX_PARITY_EN
    ef = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    ef = {1'b1, 8'hA5, 1'b0};
`endif
    clear_rx();
    busy_late = 1'b0;
    tx_if.tx_data = 8'hA5;
    tx_if.tx_valid = 1'b1;
    step;                                  // edge N: handshake
    tx_if.tx_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd1 || uart_tx !== 1'b1) begin
      bad++; $display("FAIL single_after_push level=%0d line=%b want level=1 line=1", fifo_level, uart_tx);
    end
    step;                                  // edge N+1: pop
    total++;
    if (fifo_level !== 5'd0 || uart_tx !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_after_pop level=%0d line=%b busy=%b want 0/1/1", fifo_level, uart_tx, busy);
    end
    for (int b = 0; b < NB; b++) begin
      bit_ok = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
        step;
        if (uart_tx !== ef[b]) bit_ok = 1'b0;
        if (b == NB - 1 && c == CLK_DIV - 2) busy_late = busy;
      end
      total++;
      if (!bit_ok) begin bad++; $display("FAIL single_bit%0d line not held at %b for %0d cycles", b, ef[b], CLK_DIV); end
    end
    total++;
    if (busy_late !== 1'b1) begin bad++; $display("FAIL single_busy_last got=%b want=1", busy_late); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got=%b want=0", busy); end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      bad++; $display("FAIL single_rx count=%0d want one byte A5", rx_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    int         peak;
    exp = '{8'h00, 8'hFF, 8'h55};
    clear_rx();
    peak = 0;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_if.tx_data = exp[i];
      step;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < 4 * NB * CLK_DIV && busy; i++) begin
      step;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_timeout busy=%b want=0", busy); end
    total++;
    if (peak != 2) begin bad++; $display("FAIL b2b_peak got=%0d want=2", peak); end
    total++;
    if (rx_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, rx_q[i], exp[i]); end
    end
    for (int i = 1; i < 3 && i < rx_t.size(); i++) begin
      total++;
      if (rx_t[i] - rx_t[i-1] != longint'(NB * CLK_DIV * PERIOD)) begin
        bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", i, rx_t[i] - rx_t[i-1], NB * CLK_DIV * PERIOD);
      end
    end
  endtask

  task automatic test_full;
    logic [7:0] exp [$];
    int         cnt;
    logic       ok;
    clear_rx();
    cnt = 0;
    tx_if.tx_data = 8'h10;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 200 && cnt < 17; i++) begin
      if (tx_if.tx_ready) begin
        exp.push_back(tx_if.tx_data);
        cnt++;
      end
      step;
      tx_if.tx_data = 8'(8'h10 + cnt);
    end
    total++;
    if (fifo_level !== 5'd16 || tx_if.tx_ready !== 1'b0) begin
      bad++; $display("FAIL full_level level=%0d ready=%b want 16/0", fifo_level, tx_if.tx_ready);
    end
    // Keep offering while the first pop frees a slot; the refill must land at 16 again.
    step;
    total++;
    if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_hold level=%0d want=16", fifo_level); end
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < 20 * NB * CLK_DIV && busy; i++) step;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL full_timeout busy=%b want=0", busy); end
    total++;
    if (rx_q.size() != 17) begin bad++; $display("FAIL full_count got=%0d want=17", rx_q.size()); end
    ok = 1'b1;
    for (int i = 0; i < 17 && i < rx_q.size(); i++) if (rx_q[i] !== exp[i]) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL full_order received bytes differ from the 17 accepted bytes"); end
  endtask

  task automatic test_flush;
    clear_rx();
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_if.tx_data = 8'(8'hC1 + i);
      step;
    end
    tx_if.tx_valid = 1'b0;
    repeat (60) step;                      // inside DATA of the first frame
    flush = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'hEE;
    #1;
    total++;
    if (tx_if.tx_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", tx_if.tx_ready); end
    step;
    flush = 1'b0;
    tx_if.tx_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", fifo_level); end
    for (int i = 0; i < 2 * NB * CLK_DIV && busy; i++) step;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_timeout busy=%b want=0", busy); end
    repeat (2 * NB * CLK_DIV) step;
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC1) begin
      bad++; $display("FAIL flush_rx count=%0d want one byte C1", rx_q.size());
    end
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_idle line=%b busy=%b want 1/0", uart_tx, busy);
    end
  endtask

  task automatic test_reset_mid;
    clear_rx();
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'h96;
    step;
    tx_if.tx_data = 8'h69;
    step;
    tx_if.tx_valid = 1'b0;
    repeat (99) step;                      // DATA bit 3 of the first frame
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0) begin
      bad++; $display("FAIL rstmid_async line=%b busy=%b level=%0d want 1/0/0", uart_tx, busy, fifo_level);
    end
    repeat (3) step;
    reset_n = 1'b1;
    repeat (2 * CLK_DIV) step;
    rx_ferr = 0;
    mon_en = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'h3C;
    step;
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < 2 * NB * CLK_DIV && busy; i++) step;
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || rx_ferr != 0) begin
      bad++; $display("FAIL rstmid_rx count=%0d ferr=%0d want one clean byte 3C", rx_q.size(), rx_ferr);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    clear_rx();
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = 8'h07;
    step;
    tx_if.tx_data = 8'h03;
    step;
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < 3 * NB * CLK_DIV && busy; i++) step;
    total++;
    if (rx_q.size() != 2) begin bad++; $display("FAIL parity_count got=%0d want=2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      total++;
      if (rx_p[0] !== 1'b1) begin bad++; $display("FAIL parity_07 got=%b want=1", rx_p[0]); end
      total++;
      if (rx_p[1] !== 1'b0) begin bad++; $display("FAIL parity_03 got=%b want=0", rx_p[1]); end
      total++;
      if (rx_t[1] - rx_t[0] != longint'(264 * PERIOD)) begin
        bad++; $display("FAIL parity_len got=%0d want=%0d", rx_t[1] - rx_t[0], 264 * PERIOD);
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    total++;
    if (rx_ferr != 0) begin bad++; $display("FAIL framing_errors got=%0d want=0", rx_ferr); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
